branch_predict_unit: RTL and testbench

- Parametrised next-PC unit for the 5-stage pipeline.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so the IF stage predicts branches.
- ID-stage resolution checks each prediction and issues a flush/redirect when it is wrong.
- With prediction disabled, next-PC selection is the legacy always-not-taken scheme.
- Includes saturating branch and mispredict counters for performance measurement.

---
 rtl/branch_predict_unit.sv | 146 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - next-PC unit with direct-mapped BTB, 2-bit counters and ID-stage redirect
module branch_predict_unit #(
    parameter int ADDR_W    = 16,
    parameter int IMM_W     = 9,
    parameter int BTB_DEPTH = 8,
    parameter int PRED_EN   = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_stall,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [ADDR_W-1:0] next_pc,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_branch_reg,
    input  logic [2:0]        id_ccc,
    input  logic [2:0]        id_flag,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic              id_pred_taken,
    input  logic [ADDR_W-1:0] id_pred_target,
    output logic              flush,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);
    localparam logic PRED_ON = (PRED_EN != 0);

    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt [BTB_DEPTH];
    logic [1:0]           btb_ctr [BTB_DEPTH];

    // Fetch-side lookup; instructions are halfword aligned so bit 0 is ignored
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx      = if_pc[IDX_W:1];
    assign if_tag      = if_pc[ADDR_W-1:IDX_W+1];
    assign if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign pred_taken  = PRED_ON && if_hit && btb_ctr[if_idx][1];
    assign pred_target = if_hit ? btb_tgt[if_idx] : if_pc + PC_STEP;

    logic flag_z, flag_v, flag_n, cond;

    assign flag_z = id_flag[2];
    assign flag_v = id_flag[1];
    assign flag_n = id_flag[0];

    always_comb begin
        cond = 1'b0;
        case (id_ccc)
            3'b000:  cond = !flag_z;
            3'b001:  cond = flag_z;
            3'b010:  cond = !flag_z && !flag_n;
            3'b011:  cond = flag_n;
            3'b100:  cond = flag_z || (!flag_z && !flag_n);
            3'b101:  cond = flag_n || flag_z;
            3'b110:  cond = flag_v;
            default: cond = 1'b1;
        endcase
    end

    logic              actual_taken;
    logic [ADDR_W-1:0] pcplus2, imm_sext, target;

    assign actual_taken = id_valid && id_branch && cond;
    assign pcplus2      = id_pc + PC_STEP;
    assign imm_sext     = {{(ADDR_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
    assign target       = id_branch_reg ? id_rs : pcplus2 + {imm_sext[ADDR_W-2:0], 1'b0};

    // A non-branch arriving with a taken prediction means the BTB entry aliased
    logic stale_alias;

    assign stale_alias = !id_branch && id_pred_taken;
    assign flush = id_valid && (
                       (id_branch && (actual_taken != id_pred_taken)) ||
                       (actual_taken && (id_pred_target != target)) ||
                       stale_alias);

    always_comb begin
        next_pc = if_pc + PC_STEP;
        if (flush)
            next_pc = actual_taken ? target : pcplus2;
        else if (if_stall)
            next_pc = if_pc;
        else if (pred_taken)
            next_pc = pred_target;
    end

    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    logic             id_hit, br_event;

    assign id_idx   = id_pc[IDX_W:1];
    assign id_tag   = id_pc[ADDR_W-1:IDX_W+1];
    assign id_hit   = btb_valid[id_idx] && (btb_tag[id_idx] == id_tag);
    assign br_event = id_valid && id_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_tag[i] <= '0;
                btb_tgt[i] <= '0;
                btb_ctr[i] <= 2'b01;
            end
        end else if (br_event) begin
            if (id_hit) begin
                if (actual_taken) begin
                    if (btb_ctr[id_idx] != 2'b11)
                        btb_ctr[id_idx] <= btb_ctr[id_idx] + 2'd1;
                    btb_tgt[id_idx] <= target;
                end else if (btb_ctr[id_idx] != 2'b00) begin
                    btb_ctr[id_idx] <= btb_ctr[id_idx] - 2'd1;
                end
            end else if (actual_taken) begin
                btb_valid[id_idx] <= 1'b1;
                btb_tag[id_idx]   <= id_tag;
                btb_tgt[id_idx]   <= target;
                btb_ctr[id_idx]   <= 2'b10;
            end
        end else if (id_valid && stale_alias && id_hit) begin
            btb_valid[id_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (br_event && (br_count != '1))
                br_count <= br_count + 1'b1;
            if (flush && (mispred_count != '1))
                mispred_count <= mispred_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] if_pc;
    logic        if_stall;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic [15:0] next_pc;
    logic        id_valid, id_branch, id_branch_reg, id_pred_taken;
    logic [2:0]  id_ccc, id_flag;
    logic [15:0] id_pc, id_rs, id_pred_target;
    logic [8:0]  id_imm;
    logic        flush;
    logic [15:0] br_count, mispred_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .ADDR_W(16), .IMM_W(9), .BTB_DEPTH(8), .PRED_EN(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_stall(if_stall),
        .pred_taken(pred_taken), .pred_target(pred_target), .next_pc(next_pc),
        .id_valid(id_valid), .id_branch(id_branch), .id_branch_reg(id_branch_reg),
        .id_ccc(id_ccc), .id_flag(id_flag), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs(id_rs), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .flush(flush), .br_count(br_count), .mispred_count(mispred_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        id_valid = 0; id_branch = 0; id_branch_reg = 0; id_pred_taken = 0;
        id_ccc = 3'b000; id_flag = 3'b000; id_pc = 16'h0; id_imm = 9'h0;
        id_rs = 16'h0; id_pred_target = 16'h0;
    endtask

    task automatic id_br(input logic [15:0] pc, input logic [2:0] ccc, input logic [2:0] flg,
                         input logic [8:0] imm, input logic ptaken, input logic [15:0] ptgt);
        id_valid = 1; id_branch = 1; id_branch_reg = 0; id_pc = pc; id_ccc = ccc;
        id_flag = flg; id_imm = imm; id_pred_taken = ptaken; id_pred_target = ptgt;
    endtask

    initial begin
        rst_n = 0; if_pc = 16'h0040; if_stall = 0;
        id_idle();
        #2;
        check("reset_pred_taken", pred_taken, 0);
        check("reset_next_pc", next_pc, 16'h0042);
        check("reset_br_count", br_count, 0);
        check("reset_mispred", mispred_count, 0);
        rst_n = 1;
        tick();

        // cold taken branch: miss, flush to 0x004C
        id_br(16'h0040, 3'b111, 3'b000, 9'h005, 0, 16'h0042);
        #1;
        check("cold_flush", flush, 1);
        check("cold_next_pc", next_pc, 16'h004C);
        check("cold_no_bypass", pred_taken, 0);
        tick();
        id_idle();
        #1;
        check("cold_mispred", mispred_count, 1);
        check("hit_pred_taken", pred_taken, 1);
        check("hit_pred_target", pred_target, 16'h004C);
        check("hit_next_pc", next_pc, 16'h004C);

        // three correctly predicted taken resolutions saturate ctr at 11
        for (int i = 0; i < 3; i++) begin
            id_br(16'h0040, 3'b111, 3'b000, 9'h005, 1, 16'h004C);
            #1;
            check("sat_no_flush", flush, 0);
            tick();
        end
        id_br(16'h0040, 3'b001, 3'b000, 9'h005, 1, 16'h004C);
        #1;
        check("eq_nt_flush", flush, 1);
        check("eq_nt_next_pc", next_pc, 16'h0042);
        tick();
        id_idle();
        #1;
        check("after_dec_pred_taken", pred_taken, 1);
        check("br_count_5", br_count, 5);
        check("mispred_2", mispred_count, 2);

        // BR form with stale predicted target
        id_br(16'h0040, 3'b111, 3'b000, 9'h000, 1, 16'h004C);
        id_branch_reg = 1; id_rs = 16'h1234;
        #1;
        check("br_flush", flush, 1);
        check("br_next_pc", next_pc, 16'h1234);
        tick();
        id_idle();
        #1;
        check("br_tgt_updated", pred_target, 16'h1234);

        // address wrap
        if_pc = 16'h0100;
        id_br(16'hFFFC, 3'b111, 3'b000, 9'h1FF, 1, 16'hFFFC);
        #1;
        check("wrap_back_no_flush", flush, 0);
        check("wrap_miss_next_pc", next_pc, 16'h0102);
        tick();
        id_br(16'hFFFE, 3'b111, 3'b000, 9'h000, 0, 16'h0000);
        #1;
        check("wrap_zero_flush", flush, 1);
        check("wrap_zero_next_pc", next_pc, 16'h0000);
        tick();
        id_idle();
        if_pc = 16'hFFFC;
        #1;
        check("wrap_fffc_taken", pred_taken, 1);
        check("wrap_fffc_target", pred_target, 16'hFFFC);
        if_pc = 16'hFFFE;
        #1;
        check("wrap_fffe_taken", pred_taken, 1);
        check("wrap_fffe_target", pred_target, 16'h0000);

        // stale alias: non-branch predicted taken
        id_valid = 1; id_pc = 16'hFFFE; id_pred_taken = 1; id_pred_target = 16'h0000;
        #1;
        check("alias_flush", flush, 1);
        check("alias_next_pc", next_pc, 16'h0000);
        tick();
        id_idle();
        #1;
        check("alias_invalidated", pred_taken, 0);
        check("alias_br_count", br_count, 8);
        check("alias_mispred", mispred_count, 5);

        // stall alone, then stall together with flush
        if_pc = 16'h0200; if_stall = 1;
        #1;
        check("stall_next_pc", next_pc, 16'h0200);
        id_br(16'h0300, 3'b011, 3'b001, 9'h1FE, 0, 16'h0302);
        #1;
        check("stall_flush", flush, 1);
        check("stall_flush_next_pc", next_pc, 16'h02FE);
        tick();
        id_idle();
        if_stall = 0;
        #1;
        check("br_count_9", br_count, 9);
        check("mispred_6", mispred_count, 6);

        // async reset pulse away from the clock edge
        #1 rst_n = 0;
        #1;
        check("areset_br_count", br_count, 0);
        check("areset_mispred", mispred_count, 0);
        rst_n = 1;
        if_pc = 16'h0040;
        #1;
        check("post_reset_miss_0040", pred_taken, 0);
        check("post_reset_target_0040", pred_target, 16'h0042);
        if_pc = 16'hFFFC;
        #1;
        check("post_reset_miss_fffc", pred_taken, 0);
        if_pc = 16'h0300;
        #1;
        check("post_reset_miss_0300", pred_taken, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
